pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Parametrised PLL supervisor that sits beside a board PLL wrapper and runs from the free-running reference clock. It pulses the PLL reset and qualifies the PLL lock signal with a stability window and timeout. It then releases up to seven per-clock-domain resets in a staggered order, retries on lock loss or timeout, and latches a fault after a bounded number of retries.

## Interface
- NUM_CH, 3: number of supervised output-clock domains, 1..7.
- RESET_CYCLES, 16: width of the PLL reset pulse in clk cycles, ≥1.
- LOCK_STABLE, 1024: consecutive synchronised-lock cycles required before release, ≥1.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry, ≥1.
- STAGGER, 16: cycles between successive channel releases, ≥1.
- MAX_RETRIES, 3: retries allowed before FAULT, ≥0.
- clk  in  1  free-running PLL reference clock.
- rst_n  in  1  reset, synchronous, active-low.
- pll_lock  in  1  raw PLL lock, asynchronous to clk.
- restart  in  1  single-cycle request to restart the whole sequence from any state.
- pll_reset  out  1  drives the PLL RESET pin, active-high.
- ch_rst_n  out  NUM_CH  per-domain resets, active-low, registered in clk; each consumer re-synchronises its bit.
- ready  out  1  high when all channels are released and lock is held.
- fault  out  1  sticky retry-exhaustion flag.
- retry_count  out  $clog2(MAX_RETRIES+1)  retries consumed since the last reset or restart.

## Operation
- pll_lock passes through a 2-flop synchroniser to produce lock_s. One shared counter cnt is used; its width is $clog2 of the maximum of RESET_CYCLES, LOCK_STABLE, LOCK_TIMEOUT and STAGGER·NUM_CH, plus 1.
- Reset values: state=PLLRST, cnt=0, pll_reset=1, ch_rst_n=0, ready=0, fault=0, retry_count=0.
- PLLRST: pll_reset=1 and all channels held. When cnt reaches RESET_CYCLES-1, go to WAIT_LOCK and clear cnt.
- WAIT_LOCK: pll_reset=0.
  - If lock_s=1, go to STABLE with cnt cleared.
  - Otherwise, when cnt reaches LOCK_TIMEOUT-1, perform RETRY.
- STABLE:
  - If lock_s=0, return to WAIT_LOCK with cnt cleared. This does not consume a retry.
  - When cnt reaches LOCK_STABLE-1 with lock_s still 1, go to RELEASE with cnt cleared.
- RELEASE: channel k's ch_rst_n bit rises when cnt = k·STAGGER, starting with channel 0 on the first RELEASE cycle. Bits are released in order 0..NUM_CH-1 and never re-asserted individually. After the last release, go to RUN. If lock_s=0 during RELEASE, perform RETRY.
- RUN: ready=1. If lock_s=0, perform RETRY.
- RETRY action, applied on the same edge:
  - If retry_count = MAX_RETRIES, go to FAULT.
  - Otherwise increment retry_count, go to PLLRST, clear cnt, drive all ch_rst_n=0, and drop ready.
- FAULT: pll_reset=1, ch_rst_n=0, ready=0, fault=1. Exit only via rst_n or restart.
- restart (any state): go to PLLRST, clear cnt, clear retry_count and fault, drive all ch_rst_n=0 and ready=0.
- Priority: rst_n > restart > lock-loss/timeout > count progress.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- lock_s lags pll_lock by 2 clk cycles.
- ch_rst_n[0] rises on the edge following the cycle in which lock_s has been 1 for LOCK_STABLE consecutive cycles.
- ch_rst_n[k] rises k·STAGGER cycles after ch_rst_n[0].
- ready rises on the same edge as ch_rst_n[NUM_CH-1].
- After lock_s falls in RELEASE or RUN at cycle t, ch_rst_n=0, ready=0 and pll_reset=1 appear at edge t+1.
- pll_reset is high for exactly RESET_CYCLES cycles per attempt.
- A timeout retry fires LOCK_TIMEOUT cycles after entry to WAIT_LOCK.
- rst_n low mid-sequence: every output takes its reset value at the next edge.
- restart takes effect at the next edge.

## Structure
- Package pll_sup_pkg holds:
  - the state enum (PLLRST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT);
  - a cnt-width function;
  - the constant MAX_PLL_CH=7 used for the NUM_CH bound check.
- Sub-module lock_sync: a 2-flop synchroniser with reset value 0. The same sub-module is reusable by consumers for ch_rst_n.
- Elaboration-time assertions enforce the parameter ranges.

## Test plan
Bench parameters: NUM_CH=3, RESET_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, STAGGER=2, MAX_RETRIES=2.
- Nominal: pll_lock rises 5 cycles after pll_reset falls and holds. Required: pll_reset high for exactly 4 cycles; ch_rst_n steps 001→011→111 at 2-cycle spacing; ready rises with 111; retry_count=0.
- Glitchy lock in STABLE: lock high 5 cycles, low 1 cycle, then high. Required: release only after 8 consecutive lock_s cycles; pll_reset stays 0; retry_count=0.
- Lock never asserts. Required: pll_reset re-pulses after each 32-cycle timeout; retry_count goes 1, then 2; the third timeout gives fault=1 with pll_reset held at 1 and ch_rst_n=000.
- Lock loss in RUN. Required: next edge gives ch_rst_n=000, ready=0, pll_reset=1 for 4 cycles; retry_count increments; the full sequence repeats.
- restart while in FAULT. Required: fault=0, retry_count=0, PLLRST entered. restart asserted on the same cycle as a lock loss: retry_count=0, so restart wins.
- rst_n=0 asserted mid-RELEASE with ch_rst_n=011. Required: all outputs take reset values at the next edge.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  localparam int unsigned MAX_PLL_CH = 7;

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } pll_state_e;

  // Shared counter must hold the largest terminal count any state uses.
  function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                            input int unsigned stable_cycles,
                                            input int unsigned timeout_cycles,
                                            input int unsigned stagger_span);
    int unsigned m;
    m = rst_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stagger_span > m) m = stagger_span;
    return int'($clog2(m)) + 1;
  endfunction

  function automatic int unsigned retry_width(input int unsigned max_retries);
    return (max_retries == 0) ? 1 : int'($clog2(max_retries + 1));
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_lock_sync.sv
// Two-flop synchroniser with a zero reset value; also usable by ch_rst_n consumers.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencing, lock qualification, staggered per-domain reset release,
// bounded retry with a sticky fault.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned STAGGER      = 16,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 pll_lock,
  input  logic                                 restart,
  output logic                                 pll_reset,
  output logic [NUM_CH-1:0]                    ch_rst_n,
  output logic                                 ready,
  output logic                                 fault,
  output logic [retry_width(MAX_RETRIES)-1:0]  retry_count
);

  localparam int unsigned CW = cnt_width(RESET_CYCLES, LOCK_STABLE, LOCK_TIMEOUT,
                                         STAGGER * NUM_CH);
  localparam int unsigned RW = retry_width(MAX_RETRIES);

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] REL_LAST = CW'((NUM_CH - 1) * STAGGER);
  localparam logic [RW-1:0] MAX_RET  = RW'(MAX_RETRIES);

  if (NUM_CH < 1 || NUM_CH > MAX_PLL_CH) begin : g_bad_num_ch
    $error("pll_lock_supervisor: NUM_CH must be 1..%0d", MAX_PLL_CH);
  end
  if (RESET_CYCLES < 1 || LOCK_STABLE < 1 || LOCK_TIMEOUT < 1 || STAGGER < 1) begin : g_bad_cycles
    $error("pll_lock_supervisor: cycle parameters must be >= 1");
  end

  pll_state_e        r_state;
  pll_state_e        w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [CW-1:0]     w_cnt_inc;
  logic [RW-1:0]     w_retry_nxt;
  logic              w_retry_req;
  logic              w_lock_s;
  logic              w_pll_reset_nxt;
  logic              w_ready_nxt;
  logic              w_fault_nxt;
  logic [NUM_CH-1:0] w_ch_nxt;

  lock_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  assign w_cnt_inc = r_cnt + CW'(1);

  // State, counter and every output are registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= PLLRST;
      r_cnt       <= '0;
      retry_count <= '0;
      pll_reset   <= 1'b1;
      ch_rst_n    <= '0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      retry_count <= w_retry_nxt;
      pll_reset   <= w_pll_reset_nxt;
      ch_rst_n    <= w_ch_nxt;
      ready       <= w_ready_nxt;
      fault       <= w_fault_nxt;
    end
  end

  // Next state: restart beats lock loss / timeout, which beat count progress.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = retry_count;
    w_retry_req = 1'b0;
    if (restart) begin
      w_state_nxt = PLLRST;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      unique case (r_state)
        PLLRST: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TO_LAST) begin
            w_retry_req = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        STABLE: begin
          if (!w_lock_s) begin
            w_state_nxt = WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == STB_LAST) begin
            w_state_nxt = (NUM_CH == 1) ? RUN : RELEASE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        RELEASE: begin
          if (!w_lock_s) begin
            w_retry_req = 1'b1;
          end else if (w_cnt_inc == REL_LAST) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        RUN: begin
          if (!w_lock_s) w_retry_req = 1'b1;
        end
        FAULT: begin
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = PLLRST;
          w_cnt_nxt   = '0;
        end
      endcase
      if (w_retry_req) begin
        w_cnt_nxt = '0;
        if (retry_count == MAX_RET) begin
          w_state_nxt = FAULT;
        end else begin
          w_state_nxt = PLLRST;
          w_retry_nxt = retry_count + RW'(1);
        end
      end
    end
  end

  // Outputs follow the next state so they appear on the transition edge.
  always_comb begin
    w_pll_reset_nxt = (w_state_nxt == PLLRST) || (w_state_nxt == FAULT);
    w_ready_nxt     = (w_state_nxt == RUN);
    w_fault_nxt     = (w_state_nxt == FAULT);
    w_ch_nxt        = '0;
    if (w_state_nxt == RUN) begin
      w_ch_nxt = '1;
    end else if (w_state_nxt == RELEASE) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        w_ch_nxt[k] = ((k * STAGGER) <= 32'(w_cnt_nxt));
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
module tb_pll_lock_supervisor;

  localparam int unsigned NUM_CH       = 3;
  localparam int unsigned RESET_CYCLES = 4;
  localparam int unsigned LOCK_STABLE  = 8;
  localparam int unsigned LOCK_TIMEOUT = 32;
  localparam int unsigned STAGGER      = 2;
  localparam int unsigned MAX_RETRIES  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll_lock;
  logic        restart;
  logic        pll_reset;
  logic [2:0]  ch_rst_n;
  logic        ready;
  logic        fault;
  logic [1:0]  retry_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t1, t3, t7, tr;
  bit pr_seen;
  int n, lk, g0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .NUM_CH       (NUM_CH),
    .RESET_CYCLES (RESET_CYCLES),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STAGGER      (STAGGER),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .restart     (restart),
    .pll_reset   (pll_reset),
    .ch_rst_n    (ch_rst_n),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_watch();
    t1 = -1; t3 = -1; t7 = -1; tr = -1;
    pr_seen = 1'b0;
  endtask

  // One clock; sample 1ns after the edge and note first appearance of each release step.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ch_rst_n == 3'b001 && t1 < 0) t1 = cyc;
    if (ch_rst_n == 3'b011 && t3 < 0) t3 = cyc;
    if (ch_rst_n == 3'b111 && t7 < 0) t7 = cyc;
    if (ready && tr < 0) tr = cyc;
    if (pll_reset) pr_seen = 1'b1;
  endtask

  task automatic count_pr(input logic val, output int cnt);
    cnt = 0;
    while (pll_reset == val && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
    check({tag, "_ch_rst_n"}, 32'(ch_rst_n), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_retry"}, 32'(retry_count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; pll_lock = 1'b0; restart = 1'b0;
    clr_watch();
    repeat (3) step();
    check_reset_state("rst");

    // Nominal bring-up
    rst_n = 1'b1;
    count_pr(1'b1, n);
    check("nom_pll_reset_width", n, 32'd4);
    repeat (4) step();
    pll_lock = 1'b1; lk = cyc; clr_watch();
    repeat (16) step();
    check("nom_t_ch001", t1, lk + 11);
    check("nom_t_ch011", t3, lk + 13);
    check("nom_t_ch111", t7, lk + 15);
    check("nom_t_ready", tr, lk + 15);
    check("nom_pll_reset_quiet", 32'(pr_seen), 32'd0);
    check("nom_retry", 32'(retry_count), 32'd0);

    // restart and lock loss seen by the FSM on the same edge
    pll_lock = 1'b0;
    step(); step();
    check("rl_ready_before", 32'(ready), 32'd1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rl_retry", 32'(retry_count), 32'd0);
    check("rl_pll_reset", 32'(pll_reset), 32'd1);
    check("rl_ch_rst_n", 32'(ch_rst_n), 32'd0);
    check("rl_ready", 32'(ready), 32'd0);

    // Glitchy lock: 5 high, 1 low, then high
    count_pr(1'b1, n);
    check("gl_pll_reset_width", n, 32'd4);
    g0 = cyc; clr_watch();
    pll_lock = 1'b1;
    repeat (5) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    repeat (18) step();
    check("gl_t_ch001", t1, g0 + 17);
    check("gl_t_ch011", t3, g0 + 19);
    check("gl_t_ch111", t7, g0 + 21);
    check("gl_t_ready", tr, g0 + 21);
    check("gl_pll_reset_quiet", 32'(pr_seen), 32'd0);
    check("gl_retry", 32'(retry_count), 32'd0);

    // Lock loss in RUN
    pll_lock = 1'b0;
    step(); step();
    check("ll_ready_before", 32'(ready), 32'd1);
    step();
    check("ll_ch_rst_n", 32'(ch_rst_n), 32'd0);
    check("ll_ready", 32'(ready), 32'd0);
    check("ll_pll_reset", 32'(pll_reset), 32'd1);
    check("ll_retry", 32'(retry_count), 32'd1);
    count_pr(1'b1, n);
    check("ll_pll_reset_width", n, 32'd4);
    pll_lock = 1'b1; lk = cyc; clr_watch();
    repeat (16) step();
    check("ll_t_ch001", t1, lk + 11);
    check("ll_t_ch111", t7, lk + 15);
    check("ll_t_ready", tr, lk + 15);
    check("ll_retry_after", 32'(retry_count), 32'd1);

    // Lock never asserts: two timeout retries then FAULT
    pll_lock = 1'b0; restart = 1'b1;
    step();
    restart = 1'b0;
    check("nl_retry_start", 32'(retry_count), 32'd0);
    for (int a = 1; a <= 3; a++) begin
      count_pr(1'b1, n);
      check("nl_pll_reset_width", n, 32'd4);
      count_pr(1'b0, n);
      check("nl_wait_width", n, 32'd32);
      if (a < 3) begin
        check("nl_retry", 32'(retry_count), 32'(a));
      end else begin
        check("nl_fault", 32'(fault), 32'd1);
        check("nl_fault_pll_reset", 32'(pll_reset), 32'd1);
        check("nl_fault_ch_rst_n", 32'(ch_rst_n), 32'd0);
        check("nl_fault_retry", 32'(retry_count), 32'd2);
      end
    end
    repeat (5) step();
    check("nl_fault_hold", 32'(fault), 32'd1);
    check("nl_pll_reset_hold", 32'(pll_reset), 32'd1);

    // restart out of FAULT
    restart = 1'b1; pll_lock = 1'b1;
    step();
    restart = 1'b0;
    check("rf_fault", 32'(fault), 32'd0);
    check("rf_retry", 32'(retry_count), 32'd0);
    check("rf_pll_reset", 32'(pll_reset), 32'd1);
    check("rf_ch_rst_n", 32'(ch_rst_n), 32'd0);

    // rst_n mid-RELEASE with two channels out
    n = 0;
    while (ch_rst_n != 3'b011 && n < 100) begin
      n++;
      step();
    end
    check("rs_reach_011", 32'(ch_rst_n), 32'd3);
    rst_n = 1'b0;
    step();
    check_reset_state("rs");
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
